frame_swap_ctrl: RTL and testbench

FRAME_SWAP_CTRL -- requirements
Module: frame_swap_ctrl

---
 rtl/frame_swap_ctrl.sv | 111 +++++++++++
 tb/tb_frame_swap_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_swap_ctrl.sv
// Ping-pong frame buffer controller: fills one FIFO bank while the LED driver plays the other.
// Optional saturating drop counter enabled by defining FRAME_SWAP_DROP_COUNT_EN.
module frame_swap_ctrl #(
  parameter int NUM_LEDS     = 170,
  parameter int BITS_PER_LED = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wrStrobe,
  output logic [1:0]  wrEn,
  output logic [1:0]  rdEn,
  output logic        rdBank,
  output logic        ledStart,
  input  logic        ledRead,
  input  logic        ledFinish,
  output logic        frameReady,
  output logic        dropPulse,
  output logic [15:0] dropCount
);

  localparam int FRAME_BITS = NUM_LEDS * BITS_PER_LED;
  localparam int CW         = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    PLAY  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  logic          rd_bank;
  logic          wr_full;
  logic [CW-1:0] wr_count;

  logic swap_now;
  logic accept;
  logic target;

  // A completed frame is handed over only when the reader is idle or has finished its frame.
  assign swap_now  = wr_full & ((state == IDLE) | (state == DONE));
  assign accept    = wrStrobe & (~wr_full | swap_now);
  assign target    = swap_now ? rd_bank : ~rd_bank;
  assign dropPulse = wrStrobe & wr_full & ~swap_now;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    wrEn = 2'b00;
    rdEn = 2'b00;
    if (accept) wrEn[target] = 1'b1;
    case (state)
      START:   rdEn[rd_bank] = 1'b1;
      PLAY:    rdEn[rd_bank] = ledRead;
      default: rdEn = 2'b00;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rd_bank  <= 1'b0;
      wr_full  <= 1'b0;
      wr_count <= '0;
    end else begin
      if (swap_now) begin
        // The bit arriving during the swap lands in the freshly released bank as its first bit.
        rd_bank  <= ~rd_bank;
        wr_full  <= 1'b0;
        wr_count <= accept ? CW'(1) : '0;
      end else if (accept) begin
        if (wr_count == LAST_BIT) begin
          wr_count <= '0;
          wr_full  <= 1'b1;
        end else begin
          wr_count <= wr_count + 1'b1;
        end
      end

      case (state)
        IDLE:    if (swap_now) state <= START;
        START:   state <= PLAY;
        PLAY:    if (ledFinish) state <= DONE;
        DONE:    if (swap_now) state <= START;
        default: state <= IDLE;
      endcase
    end
  end

  assign rdBank     = rd_bank;
  assign ledStart   = (state == START);
  assign frameReady = wr_full;

`ifdef FRAME_SWAP_DROP_COUNT_EN
  logic [15:0] drop_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count <= 16'd0;
    end else if (dropPulse && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end

  assign dropCount = drop_count;
`else
  assign dropCount = 16'd0;
`endif

endmodule

// File: tb/tb_frame_swap_ctrl.sv
// Directed bench for frame_swap_ctrl with a 48-bit frame (2 LEDs x 24 bits).
// Define FRAME_SWAP_DROP_COUNT_EN for both RTL and bench to exercise the drop counter.
module tb_frame_swap_ctrl;

  localparam int NUM_LEDS     = 2;
  localparam int BITS_PER_LED = 24;
  localparam int FRAME_BITS   = NUM_LEDS * BITS_PER_LED;
`ifdef FRAME_SWAP_DROP_COUNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_strobe;
  logic [1:0]  wr_en;
  logic [1:0]  rd_en;
  logic        rd_bank;
  logic        led_start;
  logic        led_read;
  logic        led_finish;
  logic        frame_ready;
  logic        drop_pulse;
  logic [15:0] drop_count;

  int checks   = 0;
  int failures = 0;

  frame_swap_ctrl #(
    .NUM_LEDS    (NUM_LEDS),
    .BITS_PER_LED(BITS_PER_LED)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wrStrobe  (wr_strobe),
    .wrEn      (wr_en),
    .rdEn      (rd_en),
    .rdBank    (rd_bank),
    .ledStart  (led_start),
    .ledRead   (led_read),
    .ledFinish (led_finish),
    .frameReady(frame_ready),
    .dropPulse (drop_pulse),
    .dropCount (drop_count)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge, away from the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_strobe = 1'b0; led_read = 1'b0; led_finish = 1'b0;
    step(); step();
    checks++;
    if ({led_start, rd_en, wr_en, rd_bank, frame_ready, drop_pulse} !== 8'b0) begin
      failures++;
      $display("FAIL reset_outputs: got start=%b rd=%b wr=%b bank=%b rdy=%b drop=%b, expected all 0",
               led_start, rd_en, wr_en, rd_bank, frame_ready, drop_pulse);
    end
    checks++;
    if (drop_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_drop_count: got %0d expected 0", drop_count);
    end
    reset = 1'b0;
    step();
  endtask

  // Fill bank1 from reset, then see the first swap start playback on bank1.
  task automatic test_first_frame();
    int wr_hits = 0;
    for (int i = 0; i < FRAME_BITS; i++) begin
      wr_strobe = 1'b1;
      #1;
      if (wr_en === 2'b10) wr_hits++;
      step();
    end
    wr_strobe = 1'b0;
    #1;
    checks++;
    if (wr_hits !== FRAME_BITS) begin
      failures++;
      $display("FAIL first_frame_writes: got %0d wrEn=10 cycles expected %0d", wr_hits, FRAME_BITS);
    end
    checks++;
    if (frame_ready !== 1'b1 || led_start !== 1'b0) begin
      failures++;
      $display("FAIL first_frame_ready: got rdy=%b start=%b expected rdy=1 start=0", frame_ready, led_start);
    end
    step();
    checks++;
    if (led_start !== 1'b1 || rd_bank !== 1'b1 || rd_en !== 2'b10) begin
      failures++;
      $display("FAIL first_start: got start=%b bank=%b rd=%b expected 1 1 10", led_start, rd_bank, rd_en);
    end
    // ledFinish during START must be ignored; next cycle is PLAY.
    led_finish = 1'b1;
    step();
    led_finish = 1'b0;
    led_read   = 1'b0;
    #1;
    checks++;
    if (led_start !== 1'b0 || rd_en !== 2'b00) begin
      failures++;
      $display("FAIL start_to_play: got start=%b rd=%b expected 0 00", led_start, rd_en);
    end
  endtask

  task automatic test_play_reads();
    int rd_hits = 0;
    for (int i = 0; i < 10; i++) begin
      led_read = 1'b1;
      #1;
      if (rd_en === 2'b10) rd_hits++;
      step();
    end
    led_read = 1'b0;
    #1;
    checks++;
    if (rd_hits !== 10) begin
      failures++;
      $display("FAIL play_reads: got %0d rdEn=10 cycles expected 10", rd_hits);
    end
    checks++;
    if (rd_en !== 2'b00) begin
      failures++;
      $display("FAIL play_read_low: got rd=%b expected 00", rd_en);
    end
  endtask

  // Fill bank0 during playback, then overflow it by three strobes.
  task automatic test_drop_in_play();
    int wr_hits = 0;
    int drops   = 0;
    for (int i = 0; i < FRAME_BITS; i++) begin
      wr_strobe = 1'b1;
      #1;
      if (wr_en === 2'b01 && drop_pulse === 1'b0) wr_hits++;
      step();
    end
    checks++;
    if (wr_hits !== FRAME_BITS || frame_ready !== 1'b1) begin
      failures++;
      $display("FAIL play_fill_bank0: got %0d writes rdy=%b expected %0d rdy=1", wr_hits, frame_ready, FRAME_BITS);
    end
    for (int i = 0; i < 3; i++) begin
      #1;
      if (drop_pulse === 1'b1 && wr_en === 2'b00) drops++;
      step();
    end
    wr_strobe = 1'b0;
    #1;
    checks++;
    if (drops !== 3) begin
      failures++;
      $display("FAIL drop_pulses: got %0d expected 3", drops);
    end
    checks++;
    if (drop_count !== (DROP_EN ? 16'd3 : 16'd0)) begin
      failures++;
      $display("FAIL drop_count_3: got %0d expected %0d", drop_count, DROP_EN ? 3 : 0);
    end
  endtask

  // Finish playback; in DONE the pending frame swaps in while a new strobe arrives.
  task automatic test_swap_from_done();
    led_finish = 1'b1;
    step();
    led_finish = 1'b0;
    wr_strobe  = 1'b1;
    led_read   = 1'b1;
    #1;
    checks++;
    if (wr_en !== 2'b10 || rd_en !== 2'b00 || drop_pulse !== 1'b0) begin
      failures++;
      $display("FAIL done_swap_cycle: got wr=%b rd=%b drop=%b expected 10 00 0", wr_en, rd_en, drop_pulse);
    end
    step();
    wr_strobe = 1'b0;
    led_read  = 1'b0;
    #1;
    checks++;
    if (rd_bank !== 1'b0 || led_start !== 1'b1 || rd_en !== 2'b01 || frame_ready !== 1'b0) begin
      failures++;
      $display("FAIL done_swap_result: got bank=%b start=%b rd=%b rdy=%b expected 0 1 01 0",
               rd_bank, led_start, rd_en, frame_ready);
    end
    // wrCount is 1 after the swap, so 47 more strobes complete the frame.
    for (int i = 0; i < FRAME_BITS - 2; i++) begin
      wr_strobe = 1'b1;
      step();
    end
    checks++;
    if (frame_ready !== 1'b0) begin
      failures++;
      $display("FAIL swap_count_early: got rdy=%b after 46 more strobes expected 0", frame_ready);
    end
    step();
    wr_strobe = 1'b0;
    #1;
    checks++;
    if (frame_ready !== 1'b1) begin
      failures++;
      $display("FAIL swap_count_full: got rdy=%b after 47 more strobes expected 1", frame_ready);
    end
  endtask

  task automatic test_drop_saturate();
    wr_strobe = 1'b1;
    for (int i = 0; i < 70000; i++) step();
    checks++;
    if (drop_count !== (DROP_EN ? 16'hFFFF : 16'd0)) begin
      failures++;
      $display("FAIL drop_saturate: got %h expected %h", drop_count, DROP_EN ? 16'hFFFF : 16'h0000);
    end
    for (int i = 0; i < 5; i++) step();
    wr_strobe = 1'b0;
    #1;
    checks++;
    if (drop_count !== (DROP_EN ? 16'hFFFF : 16'd0)) begin
      failures++;
      $display("FAIL drop_hold: got %h expected %h", drop_count, DROP_EN ? 16'hFFFF : 16'h0000);
    end
  endtask

  task automatic test_reset_mid_play();
    int starts = 0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < FRAME_BITS; i++) begin
      wr_strobe = 1'b1;
      step();
    end
    wr_strobe = 1'b0;
    step();  // swap -> START
    step();  // PLAY
    for (int i = 0; i < 20; i++) begin
      wr_strobe = 1'b1;
      step();
    end
    wr_strobe = 1'b0;
    led_read  = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({led_start, rd_en, wr_en, rd_bank, frame_ready, drop_pulse} !== 8'b0 || drop_count !== 16'd0) begin
      failures++;
      $display("FAIL async_reset: got start=%b rd=%b wr=%b bank=%b rdy=%b drop=%b cnt=%0d expected all 0",
               led_start, rd_en, wr_en, rd_bank, frame_ready, drop_pulse, drop_count);
    end
    led_read = 1'b0;
    step();
    reset = 1'b0;
    for (int i = 0; i < FRAME_BITS - 1; i++) begin
      wr_strobe = 1'b1;
      step();
      if (led_start === 1'b1) starts++;
    end
    step();
    wr_strobe = 1'b0;
    #1;
    checks++;
    if (starts !== 0 || frame_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_refill: got starts=%0d rdy=%b expected 0 1", starts, frame_ready);
    end
    step();
    checks++;
    if (led_start !== 1'b1 || rd_bank !== 1'b1) begin
      failures++;
      $display("FAIL reset_restart: got start=%b bank=%b expected 1 1", led_start, rd_bank);
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_play_reads();
    test_drop_in_play();
    test_swap_from_done();
    test_drop_saturate();
    test_reset_mid_play();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
